// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one uart_tx transmitter between
//            NUM_REQ on-chip requesters. Latches the winner's byte, drives the
//            tx_external start handshake, follows uart_busy through the
//            transmitter's ack/retransmit sequence, and returns a one-cycle
//            done pulse (plus err on timeout) to the winner.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            req, req_data   - per-requester request level and byte
//            grant, done     - one-hot owner, one-cycle completion pulse
//            err             - timeout indication, coincident with done
//            tx_data,tx_start- to uart_tx data_in / tx_external
//            uart_busy       - from uart_tx
//            arb_busy        - arbiter is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int          NUM_REQ       = 3,
  parameter int          START_TIMEOUT = 16,
  parameter logic [23:0] DONE_TIMEOUT  = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 uart_busy,
  output logic                 arb_busy
);

  localparam int               IDX_W       = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET  = IDX_W'(NUM_REQ - 1);
  localparam logic [23:0]      START_LIMIT = 24'(START_TIMEOUT - 1);
  localparam logic [23:0]      DONE_LIMIT  = DONE_TIMEOUT - 24'd1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 arb_busy_q, arb_busy_d;
  logic [23:0]          timer_q, timer_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 tmo_q, tmo_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  // (base + offs) mod NUM_REQ; offs never exceeds NUM_REQ so one wrap suffices.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int               offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Round-robin search starting just after the previous winner, so the
  // previous winner itself has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[rr_index(last_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(last_q, k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = 1'b0;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    timer_d    = timer_q;
    last_d     = last_q;
    owner_d    = owner_q;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d    = win_idx;
          grant_d    = NUM_REQ'(1) << win_idx;
          // Byte is captured once here; the requester may change it afterwards.
          tx_data_d  = req_data[{win_idx, 3'b000} +: 8];
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        tx_start_d = 1'b1;
        timer_d    = timer_q + 24'd1;
        if (uart_busy) begin
          // Drop the start request immediately so uart_tx does not re-send
          // the byte when it returns to idle.
          tx_start_d = 1'b0;
          timer_d    = '0;
          state_d    = S_WAIT_DONE;
        end else if (timer_q == START_LIMIT) begin
          tx_start_d = 1'b0;
          tmo_d      = 1'b1;
          state_d    = S_RELEASE;
        end
      end

      S_WAIT_DONE: begin
        tx_start_d = 1'b0;
        timer_d    = timer_q + 24'd1;
        if (!uart_busy) begin
          state_d = S_RELEASE;
        end else if (timer_q == DONE_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        done_d  = grant_q;
        err_d   = tmo_q;
        grant_d = '0;
        tmo_d   = 1'b0;
        timer_d = '0;
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    arb_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      arb_busy_q <= 1'b0;
      timer_q    <= '0;
      last_q     <= LAST_RESET;
      owner_q    <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      arb_busy_q <= arb_busy_d;
      timer_q    <= timer_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      tmo_q      <= tmo_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign arb_busy = arb_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter with a behavioural
//            uart_tx stand-in (busy timing, serial frame, ack check).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int          N        = 3;
  localparam int          START_TO = 16;
  localparam int          DONE_TO  = 100;
  localparam int          BAUD     = 4;
  localparam logic [7:0]  ACK_CODE = 8'd204;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant, done;
  logic           err;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           uart_busy = 1'b0;
  logic           arb_busy;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .START_TIMEOUT(START_TO),
    .DONE_TIMEOUT (24'(DONE_TO))
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .uart_busy(uart_busy),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- uart_tx stand-in ----------------
  // mode 0: never busy; 1: busy for m_hold cycles; 2: busy forever;
  // 3: serial frame on data_out followed by ack check.
  int         m_mode = 1;
  int         m_hold = 40;
  int         m_phase = 0;
  int         m_cnt = 0;
  int         m_bit = 0;
  logic [7:0] m_byte = '0;
  logic       data_out = 1'b1;
  logic [7:0] ack_line = ACK_CODE;
  int         rise_cyc = 0;
  int         fall_cyc = 0;

  initial begin : uart_model
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        uart_busy = 1'b0; m_phase = 0; m_cnt = 0; data_out = 1'b1;
      end else begin
        case (m_phase)
          0: if (tx_start && m_mode != 0) begin
               m_byte = tx_data; m_phase = 1; m_cnt = 0;
             end
          1: begin
               m_cnt++;
               if (m_cnt == 2) begin
                 uart_busy = 1'b1; rise_cyc = cyc; m_phase = 2; m_cnt = 0;
               end
             end
          2: begin
               m_cnt++;
               if (m_mode == 1) begin
                 if (m_cnt >= m_hold) begin
                   uart_busy = 1'b0; fall_cyc = cyc; m_phase = 3;
                 end
               end else if (m_mode == 3) begin
                 if (m_cnt <= 10*BAUD) begin
                   m_bit = (m_cnt - 1) / BAUD;
                   if (m_bit == 0)      data_out = 1'b0;
                   else if (m_bit == 9) data_out = 1'b1;
                   else                 data_out = m_byte[m_bit-1];
                 end else if (m_cnt == 10*BAUD + 2) begin
                   if (ack_line == ACK_CODE) begin
                     uart_busy = 1'b0; fall_cyc = cyc; m_phase = 3;
                   end else begin
                     m_cnt = 0;
                   end
                 end
               end
             end
          default: if (!tx_start) m_phase = 0;
        endcase
      end
    end
  end

  // Serial receiver watching data_out.
  logic [7:0] rx_byte = '0;
  int         rx_count = 0;
  initial begin : rx
    forever begin
      @(negedge data_out);
      repeat (BAUD/2) @(posedge clk); #3;
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(posedge clk); #3;
        rx_byte[i] = data_out;
      end
      rx_count++;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Called 1 time unit after an edge; returns at the step where done is seen.
  task automatic run_xfer(input  logic [N-1:0] r, input logic [8*N-1:0] d, input int budget,
                          output logic [N-1:0] g, output logic [7:0] td, output int g_lat,
                          output int start_len, output logic [N-1:0] dn, output logic e,
                          output int done_cyc, output logic timed_out);
    req_data = d; req = r;
    g = '0; td = '0; g_lat = -1; start_len = 0; dn = '0; e = 1'b0; done_cyc = -1;
    timed_out = 1'b1;
    for (int t = 1; t <= budget; t++) begin
      @(posedge clk); #1;
      if (tx_start) start_len++;
      if (g_lat < 0 && grant != '0) begin g = grant; td = tx_data; g_lat = t; end
      if (done != '0) begin
        dn = done; e = err; done_cyc = cyc; req = '0; timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) req = '0;
  endtask

  typedef struct {
    logic [N-1:0]   r;
    logic [8*N-1:0] d;
    logic [N-1:0]   exp_g;
    logic [7:0]     exp_b;
  } vec_t;

  initial begin : global_guard
    #3_000_000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    vec_t           tbl[7];
    logic [N-1:0]   g, dn, ex, rae, pg, pd;
    logic [7:0]     td, byte_exp;
    logic           e, to, draining;
    int             lat, slen, dcyc, ng, nd, owner, exp_last, w, completed, waited;

    tbl[0] = '{3'b010, {8'h33, 8'hA5, 8'h11}, 3'b010, 8'hA5};
    tbl[1] = '{3'b111, {8'hC3, 8'hB2, 8'hA1}, 3'b100, 8'hC3};
    tbl[2] = '{3'b011, {8'h00, 8'h5A, 8'h69}, 3'b001, 8'h69};
    tbl[3] = '{3'b110, {8'hF0, 8'h0F, 8'hFF}, 3'b010, 8'h0F};
    tbl[4] = '{3'b101, {8'h12, 8'h34, 8'h56}, 3'b100, 8'h12};
    tbl[5] = '{3'b001, {8'h77, 8'h88, 8'h99}, 3'b001, 8'h99};
    tbl[6] = '{3'b100, {8'hDE, 8'hAD, 8'hBE}, 3'b100, 8'hDE};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_arb_busy", arb_busy, 0);
    reset = 1'b0;

    // Table-driven single transfers, round robin from reset.
    for (int i = 0; i < 7; i++) begin
      m_mode = 1;
      m_hold = (i == 0) ? 40 : 5 + i;
      run_xfer(tbl[i].r, tbl[i].d, 200, g, td, lat, slen, dn, e, dcyc, to);
      check("tbl_no_timeout", to, 0);
      check("tbl_grant", g, tbl[i].exp_g);
      check("tbl_tx_data", td, tbl[i].exp_b);
      check("tbl_grant_latency", lat, 1);
      check("tbl_done", dn, tbl[i].exp_g);
      check("tbl_err", e, 0);
      if (i == 0) begin
        check("single_tx_start_len", slen, 3);
        check("single_done_after_fall", dcyc - fall_cyc, 2);
      end
      @(posedge clk); #1;
      check("tbl_done_one_pulse", done, 0);
    end

    // Fairness: all requesters held for 6 transfers.
    do_reset();
    m_mode = 1; m_hold = 4;
    req_data = {8'h03, 8'h02, 8'h01};
    req = '1; ng = 0; nd = 0; pg = '0;
    for (int t = 0; t < 600 && nd < 6; t++) begin
      @(posedge clk); #1;
      if (grant != '0 && pg == '0) begin
        check("fair_grant", grant, 32'(1) << (ng % 3));
        ng++;
      end
      if (done != '0) begin
        check("fair_done_per_grant", nd + 1, ng);
        nd++;
        if (nd == 6) req = '0;
      end
      pg = grant;
    end
    check("fair_done_count", nd, 6);
    check("fair_grant_count", ng, 6);
    @(posedge clk); #1;

    // Start timeout: uart never busy.
    m_mode = 0;
    run_xfer(3'b001, {8'h00, 8'h00, 8'h42}, 100, g, td, lat, slen, dn, e, dcyc, to);
    check("start_to_no_hang", to, 0);
    check("start_to_tx_start_len", slen, START_TO);
    check("start_to_done", dn, 3'b001);
    check("start_to_err", e, 1);
    check("start_to_idle", arb_busy, 0);
    @(posedge clk); #1;

    // Done timeout: busy rises and never falls.
    m_mode = 2;
    run_xfer(3'b100, {8'h5E, 8'h00, 8'h00}, 300, g, td, lat, slen, dn, e, dcyc, to);
    check("done_to_no_hang", to, 0);
    check("done_to_done", dn, 3'b100);
    check("done_to_err", e, 1);
    check("done_to_latency", dcyc - (rise_cyc + 1), DONE_TO + 1);

    // Reset in WAIT_DONE.
    do_reset();
    m_mode = 1; m_hold = 40;
    req_data = {8'h00, 8'h00, 8'h7E}; req = 3'b001;
    waited = 0;
    while (!uart_busy && waited < 30) begin
      @(posedge clk); #1; waited++;
    end
    check("rstmid_reached_busy", uart_busy, 1);
    reset = 1'b1; req = '0;
    @(posedge clk); #1;
    check("rstmid_outputs_zero", {grant, done, err, tx_start, tx_data, arb_busy}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_xfer(3'b110, {8'hB6, 8'hA6, 8'h00}, 200, g, td, lat, slen, dn, e, dcyc, to);
    check("rstmid_first_grant", g, 3'b010);
    check("rstmid_latency", lat, 1);
    check("rstmid_tx_data", td, 8'hA6);
    @(posedge clk); #1;

    // Serial transfer through the uart stand-in with ack.
    m_mode = 3;
    byte_exp = 8'($urandom);
    ng = rx_count;
    run_xfer(3'b001, {8'h00, 8'h00, byte_exp}, 300, g, td, lat, slen, dn, e, dcyc, to);
    check("uart_no_hang", to, 0);
    check("uart_latched", td, byte_exp);
    check("uart_frames", rx_count - ng, 1);
    check("uart_serial_byte", rx_byte, td);
    check("uart_done_after_fall", dcyc - fall_cyc, 2);
    check("uart_err", e, 0);
    @(posedge clk); #1;

    // Withdrawn request: transfer still completes.
    m_mode = 1; m_hold = 6;
    req_data = {8'h9C, 8'h00, 8'h00}; req = 3'b100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = '0;
    dn = '0;
    for (int t = 0; t < 60 && dn == '0; t++) begin
      @(posedge clk); #1;
      if (done != '0) begin dn = done; e = err; end
    end
    check("withdrawn_done", dn, 3'b100);
    check("withdrawn_err", e, 0);
    @(posedge clk); #1;

    // Randomized traffic against a round-robin reference.
    do_reset();
    m_mode = 1;
    exp_last = N - 1; owner = 0; completed = 0; draining = 1'b0;
    pg = '0; pd = '0;
    for (int t = 0; t < 2500; t++) begin
      @(posedge clk); #1;
      rae = req;
      if (grant != '0 && pg == '0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && rae[(exp_last + k) % N]) w = (exp_last + k) % N;
        ex = '0;
        if (w >= 0) ex[w] = 1'b1;
        check("rand_grant", grant, ex);
        if (w >= 0) check("rand_tx_data", tx_data, req_data[8*w +: 8]);
        owner  = w;
        m_hold = $urandom_range(1, 30);
      end
      if (pd != '0) check("rand_done_one_pulse", done, 0);
      if (done != '0) begin
        ex = '0;
        if (owner >= 0) ex[owner] = 1'b1;
        check("rand_done", done, ex);
        check("rand_err", err, 0);
        exp_last = owner;
        req[owner] = 1'b0;
        completed++;
      end
      if (t >= 2000) draining = 1'b1;
      if (!draining) begin
        for (int i = 0; i < N; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            req_data[8*i +: 8] = 8'($urandom);
            req[i] = 1'b1;
          end
        end
      end
      pg = grant; pd = done;
      if (draining && req == '0 && !arb_busy && done == '0) break;
    end
    check("rand_no_lost_request", req, 0);
    check("rand_some_completed", completed > 10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
